// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA exponentiation controller.
package rsa_pkg;

  localparam int unsigned DATA_W = 13;
  localparam int unsigned RES_W  = 16;

  localparam int unsigned E_DEFAULT = 17;
  localparam int unsigned N_DEFAULT = 3233;

  localparam logic [1:0] OP_ENC    = 2'b00;
  localparam logic [1:0] OP_LOAD_E = 2'b01;
  localparam logic [1:0] OP_LOAD_N = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic [3:0] {
    SYNC_E,
    SYNC_N,
    IDLE,
    INIT,
    CHECK,
    MUL,
    MOD,
    DONE,
    WAIT,
    LOAD,
    RESP
  } rsa_state_e;

endpackage

// File: rtl/rsa_ctrl_resp_slot.sv
// Single-entry result register with valid/ready; loads on request, clears on handshake.
module rsa_ctrl_resp_slot
  import rsa_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [RES_W-1:0] load_data,
  input  logic             load_err,
  input  logic             ready,
  output logic             valid,
  output logic [RES_W-1:0] data,
  output logic             err
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
      err   <= load_err;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/rsa_controller.sv
// Control FSM sequencing the RSA modular-exponentiation datapath.
// Optional feature: RSA_CTRL_ERR_RESP_EN answers reserved op 11 with an error response.
module rsa_controller
  import rsa_pkg::*;
#(
  parameter int unsigned E_DEFAULT = rsa_pkg::E_DEFAULT,
  parameter int unsigned N_DEFAULT = rsa_pkg::N_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic [DATA_W-1:0] dp_data,
  output logic              dp_initialize,
  output logic              dp_en_multiply,
  output logic              dp_en_modulo,
  output logic              dp_done,
  output logic              dp_update_e,
  output logic              dp_update_n,
  input  logic              dp_mult_done,
  input  logic [RES_W-1:0]  dp_result,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
  output logic              res_err
);

  rsa_state_e        state, state_nxt;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] e_shadow;
  logic              accept;
  logic              e_zero;
  logic              slot_load;
  logic [RES_W-1:0]  slot_data;
  logic              slot_err;

  assign accept = (state == IDLE) && cmd_valid;
  assign e_zero = (e_shadow == '0);

  // State register; reset replays the default keys into the datapath.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= SYNC_E;
    else        state <= state_nxt;
  end

  // Command capture and exponent shadow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP_ENC;
      data_q   <= '0;
      e_shadow <= DATA_W'(E_DEFAULT);
    end else if (accept) begin
      op_q   <= cmd_op;
      data_q <= cmd_data;
      if (cmd_op == OP_LOAD_E) e_shadow <= cmd_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      SYNC_E: state_nxt = SYNC_N;
      SYNC_N: state_nxt = IDLE;
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_ENC:    state_nxt = e_zero ? RESP : INIT;
            OP_LOAD_E: state_nxt = LOAD;
            OP_LOAD_N: state_nxt = LOAD;
`ifdef RSA_CTRL_ERR_RESP_EN
            default:   state_nxt = RESP;
`else
            default:   state_nxt = IDLE;
`endif
          endcase
        end
      end
      INIT:    state_nxt = CHECK;
      CHECK:   state_nxt = dp_mult_done ? DONE : MUL;
      MUL:     state_nxt = MOD;
      MOD:     state_nxt = CHECK;
      DONE:    state_nxt = WAIT;
      WAIT:    state_nxt = RESP;
      LOAD:    state_nxt = IDLE;
      RESP:    if (res_valid && res_ready) state_nxt = IDLE;
      default: state_nxt = SYNC_E;
    endcase
  end

  // Moore decode of the state register onto the datapath strobes.
  always_comb begin
    cmd_ready      = 1'b0;
    dp_data        = data_q;
    dp_initialize  = 1'b0;
    dp_en_multiply = 1'b0;
    dp_en_modulo   = 1'b0;
    dp_done        = 1'b0;
    dp_update_e    = 1'b0;
    dp_update_n    = 1'b0;
    case (state)
      SYNC_E: begin
        dp_data     = DATA_W'(E_DEFAULT);
        dp_update_e = 1'b1;
      end
      SYNC_N: begin
        dp_data     = DATA_W'(N_DEFAULT);
        dp_update_n = 1'b1;
      end
      IDLE:  cmd_ready      = 1'b1;
      INIT:  dp_initialize  = 1'b1;
      MUL:   dp_en_multiply = 1'b1;
      MOD:   dp_en_modulo   = 1'b1;
      DONE:  dp_done        = 1'b1;
      LOAD: begin
        dp_update_e = (op_q == OP_LOAD_E);
        dp_update_n = (op_q == OP_LOAD_N);
      end
      default: ;
    endcase
  end

  // Result slot sources: datapath capture in WAIT, or immediate answers from IDLE.
  always_comb begin
    slot_load = 1'b0;
    slot_data = dp_result;
    slot_err  = 1'b0;
    if (state == WAIT) begin
      slot_load = 1'b1;
    end else if (accept && (cmd_op == OP_ENC) && e_zero) begin
      slot_load = 1'b1;
      slot_data = RES_W'(1);
    end
`ifdef RSA_CTRL_ERR_RESP_EN
    else if (accept && (cmd_op == OP_RSVD)) begin
      slot_load = 1'b1;
      slot_data = '0;
      slot_err  = 1'b1;
    end
`endif
  end

  rsa_ctrl_resp_slot u_resp_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (slot_load),
    .load_data (slot_data),
    .load_err  (slot_err),
    .ready     (res_ready),
    .valid     (res_valid),
    .data      (res_data),
    .err       (res_err)
  );

endmodule

// File: tb/tb_rsa_controller.sv
// Directed bench for rsa_controller with a behavioural square-free exponentiation datapath.
module tb_rsa_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [12:0] cmd_data = '0;
  logic [12:0] dp_data;
  logic        dp_initialize, dp_en_multiply, dp_en_modulo, dp_done;
  logic        dp_update_e, dp_update_n;
  logic        dp_mult_done;
  logic [15:0] dp_result;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] res_data;
  logic        res_err;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  rsa_controller dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_op         (cmd_op),
    .cmd_data       (cmd_data),
    .dp_data        (dp_data),
    .dp_initialize  (dp_initialize),
    .dp_en_multiply (dp_en_multiply),
    .dp_en_modulo   (dp_en_modulo),
    .dp_done        (dp_done),
    .dp_update_e    (dp_update_e),
    .dp_update_n    (dp_update_n),
    .dp_mult_done   (dp_mult_done),
    .dp_result      (dp_result),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .res_err        (res_err)
  );

  // Datapath model: acc = m^e mod n using e-1 multiply/modulo pairs.
  logic [12:0] m_e = '0;
  logic [12:0] m_n = 13'd1;
  logic [12:0] m_cnt = '0;
  logic [31:0] m_acc = '0;
  logic [31:0] m_base = '0;
  int mul_pulses = 0;
  int init_pulses = 0;
  int overlap = 0;

  assign dp_mult_done = (m_cnt == 13'd0);
  assign dp_result    = m_acc[15:0];

  always @(posedge clk) begin
    if (dp_update_e) m_e <= dp_data;
    if (dp_update_n) m_n <= dp_data;
    if (dp_initialize) begin
      m_base <= {24'd0, dp_data[7:0]};
      m_acc  <= {24'd0, dp_data[7:0]};
      m_cnt  <= m_e - 13'd1;
      init_pulses <= init_pulses + 1;
    end
    if (dp_en_multiply) begin
      m_acc <= m_acc * m_base;
      mul_pulses <= mul_pulses + 1;
    end
    if (dp_en_modulo) begin
      m_acc <= m_acc % {19'd0, m_n};
      m_cnt <= m_cnt - 13'd1;
    end
  end

  always @(negedge clk) begin
    if ((32'(dp_initialize) + 32'(dp_en_multiply) + 32'(dp_en_modulo) + 32'(dp_done)
         + 32'(dp_update_e) + 32'(dp_update_n)) > 32'd1)
      overlap <= overlap + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", 32'(cmd_ready), 32'd1);
  endtask

  // Presents one command at a negedge; returns at the negedge of cycle 1 after accept.
  task automatic send(input logic [1:0] op, input logic [12:0] data);
    wait_ready();
    cmd_op    = op;
    cmd_data  = data;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(output int cyc);
    cyc = 1;
    while (!res_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  int cyc;
  int snap;

  initial begin
    // Reset state: SYNC_E decoded while rst_n is held low.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_res_err", 32'(res_err), 32'd0);
    check("rst_upd_e", 32'(dp_update_e), 32'd1);
    check("rst_e_val", 32'(dp_data), 32'd17);
    rst_n = 1'b1;
    @(negedge clk);
    check("sync_upd_n", 32'(dp_update_n), 32'd1);
    check("sync_n_val", 32'(dp_data), 32'd3233);
    check("sync_not_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("idle_ready", 32'(cmd_ready), 32'd1);
    check("dp_keys_e", 32'(m_e), 32'd17);
    check("dp_keys_n", 32'(m_n), 32'd3233);

    // Default key encrypt.
    send(2'b00, 13'd65);
    wait_resp(cyc);
    check("enc65_lat", 32'(cyc), 32'd53);
    check("enc65_data", 32'(res_data), 32'd2790);
    check("enc65_err", 32'(res_err), 32'd0);
    @(negedge clk);
    check("post_hs_ready", 32'(cmd_ready), 32'd1);
    check("post_hs_valid", 32'(res_valid), 32'd0);

    // Load e=1 then encrypt: no multiplies.
    send(2'b01, 13'd1);
    check("lde_strobe", 32'(dp_update_e), 32'd1);
    check("lde_data", 32'(dp_data), 32'd1);
    check("lde_ready_lo", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("lde_ready_hi", 32'(cmd_ready), 32'd1);
    snap = mul_pulses;
    send(2'b00, 13'd200);
    wait_resp(cyc);
    check("e1_lat", 32'(cyc), 32'd5);
    check("e1_data", 32'(res_data), 32'd200);
    check("e1_muls", 32'(mul_pulses - snap), 32'd0);
    @(negedge clk);

    // Load e=0 then encrypt: immediate answer of 1.
    send(2'b01, 13'd0);
    @(negedge clk);
    snap = init_pulses;
    send(2'b00, 13'd5);
    check("e0_lat_valid", 32'(res_valid), 32'd1);
    check("e0_data", 32'(res_data), 32'd1);
    @(negedge clk);
    check("e0_no_init", 32'(init_pulses - snap), 32'd0);

    // Backpressure during RESP.
    res_ready = 1'b0;
    send(2'b00, 13'd7);
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", 32'(res_valid), 32'd1);
      check("hold_data", 32'(res_data), 32'd1);
      check("hold_ready", 32'(cmd_ready), 32'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("hold_release_valid", 32'(res_valid), 32'd0);
    check("hold_release_ready", 32'(cmd_ready), 32'd1);

    // Load n passes the 13-bit value unchanged, then restore.
    send(2'b10, 13'h1ABC);
    check("ldn_strobe", 32'(dp_update_n), 32'd1);
    check("ldn_data", 32'(dp_data), 32'h1ABC);
    check("ldn_no_e", 32'(dp_update_e), 32'd0);
    @(negedge clk);
    send(2'b10, 13'd3233);
    @(negedge clk);

    // Reset mid-MUL with e=17 aborts and replays the key sync.
    send(2'b01, 13'd17);
    @(negedge clk);
    send(2'b00, 13'd65);
    cyc = 0;
    while (!dp_en_multiply && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("mid_mul_reached", 32'(dp_en_multiply), 32'd1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_upd_e", 32'(dp_update_e), 32'd1);
    check("abort_e_val", 32'(dp_data), 32'd17);
    check("abort_valid", 32'(res_valid), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_upd_n", 32'(dp_update_n), 32'd1);
    @(negedge clk);
    check("abort_idle", 32'(cmd_ready), 32'd1);
    check("abort_no_resp", 32'(res_valid), 32'd0);
    send(2'b00, 13'd65);
    wait_resp(cyc);
    check("re_enc_lat", 32'(cyc), 32'd53);
    check("re_enc_data", 32'(res_data), 32'd2790);
    @(negedge clk);

    // Reserved opcode.
    snap = init_pulses;
    send(2'b11, 13'd99);
`ifdef RSA_CTRL_ERR_RESP_EN
    check("rsvd_valid", 32'(res_valid), 32'd1);
    check("rsvd_err", 32'(res_err), 32'd1);
    check("rsvd_data", 32'(res_data), 32'd0);
    @(negedge clk);
    check("rsvd_single", 32'(res_valid), 32'd0);
    check("rsvd_ready", 32'(cmd_ready), 32'd1);
`else
    check("rsvd_ready", 32'(cmd_ready), 32'd1);
    check("rsvd_no_resp", 32'(res_valid), 32'd0);
    check("rsvd_err_tied", 32'(res_err), 32'd0);
    repeat (3) @(negedge clk);
    check("rsvd_still_none", 32'(res_valid), 32'd0);
`endif
    check("rsvd_no_init", 32'(init_pulses - snap), 32'd0);

    check("one_hot_strobes", 32'(overlap), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
